// File: rtl/serial_sub4.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// behind a start/busy/done handshake. D/Bout update only on the completion edge.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled on a rising edge only while busy is low
  // (IDLE or DONE); that edge captures A/B/Bin. busy stays high for WIDTH
  // cycles, then done pulses for one cycle with D/Bout valid from then on.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             b_bit;
  logic             diff;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  assign a_bit   = a_sr[0];
  assign b_bit   = b_sr[0];
  assign diff    = a_bit ^ b_bit ^ br;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  // The final difference is taken from d_next so D lands on the same edge
  // as the last bit rather than one cycle later.
  assign d_next  = {diff, d_sr[WIDTH-1:1]};

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
            d_sr  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            D     <= d_next;
            Bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4: directed vectors plus an exhaustive sweep, checked by
// a done-driven monitor against a queue of expected {Bout, D} results.
module tb_serial_sub4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  serial_sub4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .D         (D),
    .Bout      (Bout),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0]       exp_q[$];   // {Bout, D}
  logic [2*WIDTH:0]     in_q[$];    // {A, B, Bin}
  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;
  int done_cyc   = 0;
  int accept_cyc = 0;
  int busy_run   = 0;
  logic [WIDTH-1:0] prev_d    = '0;
  logic             prev_bout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0d req=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] add_ripple(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic c);
    logic [WIDTH-1:0] s;
    logic cc;
    cc = c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [WIDTH:0]   e;
    logic [2*WIDTH:0] in;
    #1;
    if (rst) begin
      prev_d    = '0;
      prev_bout = 1'b0;
      busy_run  = 0;
    end else begin
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("busy_cycles", 32'(busy_run), 32'(WIDTH));
        busy_run = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          in = in_q.pop_front();
          check("result_d", 32'(D), 32'(e[WIDTH-1:0]));
          check("result_bout", 32'(Bout), 32'(e[WIDTH]));
          check("adder_roundtrip", 32'(add_ripple(D, in[WIDTH:1], in[0])),
                32'(in[2*WIDTH:WIDTH+1]));
        end
      end else begin
        check("d_hold", 32'(D), 32'(prev_d));
        check("bout_hold", 32'(Bout), 32'(prev_bout));
      end
      if (busy) busy_run++;
      prev_d    = D;
      prev_bout = Bout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] ed, input logic eb);
    exp_q.push_back({eb, ed});
    in_q.push_back({a, b, bin});
  endtask

  // Issue one request from an idle/done DUT; returns in the first busy cycle.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input logic [WIDTH-1:0] ed, input logic eb,
                       input bit push);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    if (push) push_exp(a, b, bin, ed, eb);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    check("accept_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    A   = WIDTH'($urandom_range(0, 15));
    B   = WIDTH'($urandom_range(0, 15));
    Bin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_count < target && k < 30) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (done_count < target) check("done_timeout", 32'(done_count), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_d", 32'(D), 32'd0);
    check("reset_bout", 32'(Bout), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // zero operands, latency
    issue(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    wait_done(1);
    check("latency_edges", 32'(done_cyc - accept_cyc + 1), 32'(WIDTH + 1));

    issue(4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b1); wait_done(2);
    issue(4'd0,  4'd1,  1'b0, 4'd15, 1'b1, 1'b1); wait_done(3);
    issue(4'd5,  4'd3,  1'b1, 4'd1,  1'b0, 1'b1); wait_done(4);
    issue(4'd15, 4'd0,  1'b1, 4'd14, 1'b0, 1'b1); wait_done(5);
    issue(4'd3,  4'd3,  1'b1, 4'd15, 1'b1, 1'b1); wait_done(6);

    // start during SHIFT is ignored
    issue(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd2;
    @(negedge clk);
    start = 1'b0; A = 4'd12; B = 4'd13;
    wait_done(7);
    repeat (8) @(negedge clk);
    check("single_done", 32'(done_count), 32'd7);

    // start held high: back-to-back results
    base = done_count;
    for (int i = 0; i < 3; i++) push_exp(4'd10, 4'd7, 1'b0, 4'd3, 1'b0);
    @(negedge clk);
    A = 4'd10; B = 4'd7; Bin = 1'b0; start = 1'b1;
    wait_done(base + 1);
    accept_cyc = done_cyc;
    wait_done(base + 2);
    check("b2b_period", 32'(done_cyc - accept_cyc), 32'(WIDTH + 1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 3);

    // reset aborts an in-flight operation
    base = done_count;
    issue(4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b1);
    wait_done(base + 1);
    issue(4'd1, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_d", 32'(D), 32'd0);
    check("abort_bout", 32'(Bout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(base + 1));
    issue(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    wait_done(base + 2);

    // exhaustive sweep, expected values from the arithmetic contract
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          base = done_count;
          issue(4'(a), 4'(b), 1'(c), 4'((a - b - c) & 15), 1'(a < b + c), 1'b1);
          wait_done(base + 1);
        end
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
